// File: rtl/pushbutton_input_port.sv
// ---------------------------------------------------------------------------
// pushbutton_input_port
//
// Avalon-MM slave that samples a bank of pushbuttons.  Each bit is brought
// to the requested polarity, passed through a 2-flop synchronizer and then
// debounced.  The debounced level, an interrupt mask and a press-event
// (edge) capture register are presented to the processor.  irq is raised
// while any captured press is also enabled in the mask.
//
// Register map (word address):
//   0 : data          RO   debounced level, 1 = pressed
//   1 : reserved      reads 0, writes ignored
//   2 : interrupt mask R/W
//   3 : edge capture  R, write 1 to clear
//
// Parameters:
//   DW              number of buttons minus 1
//   DEBOUNCE_CYCLES consecutive stable samples needed to accept a change (>= 2)
//   CNT_W           debounce counter width, must hold DEBOUNCE_CYCLES-1
//   INVERT          1 = pins are active-low
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register select
//   byteenable  byte lanes for writes
//   chipselect  slave select
//   read        read strobe (reads are qualified by chipselect alone)
//   write       write strobe
//   writedata   write data
//   KEY         raw asynchronous button pins
//   readdata    registered read data, 1 cycle latency
//   irq         interrupt request, active-high
// ---------------------------------------------------------------------------
module pushbutton_input_port #(
   parameter int DW              = 3,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit INVERT          = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic [3:0]  byteenable,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [DW:0] KEY,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [DW:0] key_pol;
   logic [DW:0] sync1_reg;
   logic [DW:0] sync2_reg;
   logic [DW:0] stable;
   logic [DW:0] stable_d_reg;
   logic [DW:0] rising;
   logic [DW:0] edge_reg;
   logic [DW:0] edge_next;
   logic [DW:0] edge_clr;
   logic [DW:0] mask_reg;
   logic [DW:0] mask_next;
   logic [31:0] read_mux;
   logic        mask_wr;
   logic        edge_wr;

   // The read strobe and the data/byte lanes above the button count carry
   // no information for this port; reads only need chipselect.
   logic unused_bits;
   assign unused_bits = ^{read, writedata, byteenable};

   // Bring every pin to "1 = pressed" before synchronizing, so that the
   // all-zero reset state corresponds to all buttons released.
   assign key_pol = KEY ^ {(DW + 1){INVERT}};

   assign mask_wr = chipselect & write & (address == 2'd2);
   assign edge_wr = chipselect & write & (address == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= key_pol;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi <= DW; gi++) begin : g_bit
         logic [CNT_W-1:0] cnt_reg;
         logic             stable_reg;

         // Counts consecutive samples that disagree with the accepted level.
         // Any sample matching the accepted level restarts the count, so a
         // bounce back never lets a partial count carry over.
         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_reg    <= '0;
               stable_reg <= 1'b0;
            end else if (sync2_reg[gi] == stable_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
               stable_reg <= sync2_reg[gi];
               cnt_reg    <= '0;
            end else begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign stable[gi] = stable_reg;

         // Byte lane gi/8 qualifies both the clear and the mask update.
         assign edge_clr[gi]  = edge_wr & writedata[gi] & byteenable[gi / 8];
         assign mask_next[gi] = (mask_wr & byteenable[gi / 8]) ? writedata[gi]
                                                               : mask_reg[gi];
      end
   endgenerate

   // Only presses are captured; releases are ignored.
   assign rising = stable & ~stable_d_reg;

   // Set has priority over a simultaneous software clear so that a press
   // landing on the clear cycle is never lost.
   assign edge_next = (edge_reg & ~edge_clr) | rising;

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_d_reg <= '0;
         edge_reg     <= '0;
         mask_reg     <= '0;
      end else begin
         stable_d_reg <= stable;
         edge_reg     <= edge_next;
         mask_reg     <= mask_next;
      end
   end

   always_comb begin
      read_mux = '0;
      case (address)
         2'd0:    read_mux = 32'(stable);
         2'd2:    read_mux = 32'(mask_reg);
         2'd3:    read_mux = 32'(edge_reg);
         default: read_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else if (chipselect) begin
         readdata <= read_mux;
      end
   end

   // Level-sensitive: stays high until software clears or masks the event.
   assign irq = |(edge_reg & mask_reg);

endmodule

// File: doc/pushbutton_input_port.md
# pushbutton_input_port

Avalon-MM memory-mapped slave that samples a bank of external pushbuttons, synchronizes and debounces each bit, and presents level, interrupt-mask and edge-capture registers to the processor. It is the input-direction counterpart of the HEX display output ports on the same system interconnect. It also provides a level-sensitive interrupt request to the CPU.

## Interface

- DW, 3, data width minus 1 (number of buttons = DW+1)
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a change (≥2)
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
- INVERT, 1, 1 = inputs active-low (pressed = 0 on pin, reads as 1)

- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- address  input  2  register select
- byteenable  input  4  byte lanes for writes
- chipselect  input  1  slave select
- read  input  1  read strobe
- write  input  1  write strobe
- writedata  input  32  write data
- KEY  input  DW+1  raw asynchronous button pins
- readdata  output  32  registered read data
- irq  output  1  interrupt request, active-high

## Operation

- Register map: 0 = data (RO, debounced level), 1 = reserved (reads 0, writes ignored), 2 = interrupt mask (R/W), 3 = edge capture (R, write-1-to-clear).
- Input path per bit: polarity (XOR with INVERT) → 2-flop synchronizer (sync1, sync2) → debouncer → stable → edge detector.
- Debouncer per bit: counter cnt. If sync2 == stable, cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1, stable <= sync2 and cnt <= 0. Else cnt <= cnt+1. Any bounce back to the stable value restarts the count.
- Edge detector: stable_d <= stable every cycle; rising = stable & ~stable_d (press event only; releases are not captured).
- Edge capture: edge[i] <= (edge[i] & ~clr[i]) | rising[i], where clr[i] = chipselect & write & address==3 & writedata[i] & byteenable[i/8]. A set and a clear in the same cycle: set wins, bit stays 1.
- Interrupt mask: on chipselect & write & address==2, each byte lane with byteenable set updates mask bits from writedata. Bits above DW do not exist and read 0.
- irq = |(edge & mask). It is combinational from registers and asserted until software clears the edge bits or masks them.
- Writes to address 0 or 1 have no effect.

## Timing

- Reset values: readdata = 0, irq = 0, mask = 0, edge = 0, stable = 0, stable_d = 0, cnt = 0, sync1/sync2 = 0 (i.e. all buttons released).
- Reads: on a clock edge with chipselect = 1, readdata <= selected register (zero-extended). Latency is 1 cycle. With chipselect = 0, readdata holds. The read strobe is not required for the update.
- Pin-to-stable latency: suppose the pin changes before edge k and stays stable. Then sync2 reflects it after edge k+1, and stable updates at edge k+1+DEBOUNCE_CYCLES.
- Edge capture sets at the edge after stable rises. irq asserts in the same cycle edge sets, if the bit is masked in.
- A glitch shorter than DEBOUNCE_CYCLES cycles after synchronization never changes stable.
- A mask write takes effect on irq in the cycle after the write edge. An edge clear deasserts irq in the cycle after the write edge, unless a new rising event coincides.
- Reset asserted mid-debounce discards the count. Buttons held through reset are re-accepted as a press DEBOUNCE_CYCLES+2 cycles after reset release and generate an edge.

## Test plan

Use DEBOUNCE_CYCLES = 4 and INVERT = 1 throughout.

- Reset → readdata, irq, and reads of addresses 0/1/2/3 all return 0x00000000.
- Drive KEY=4'b1110 and hold it → data reads 0x1 only after stable updates (edge k+5). Edge-capture bit 0 sets one cycle later. irq stays 0 with mask=0.
- Bounce: KEY[1] low for 3 cycles, high for 1, low for 3, then high → stable[1] never sets, and edge capture reads 0.
- Write mask=0xF, press KEY[2] → edge reads 0x4 and irq=1. Write 0x4 to address 3 → edge=0 and irq=0 the next cycle.
- Make a software clear of bit 0 coincide with a new rising event on bit 0 → edge bit 0 remains 1 and irq remains 1.
- Write 0xFFFFFFFF to mask with byteenable=4'b0000 → mask stays 0. Write to address 0 → data is unaffected.
